cpu_onchip_ram_dp: RTL and testbench
====================================

CPU_ONCHIP_RAM_DP -- requirements
Module: cpu_onchip_ram_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 153600: number of words.
REQ-003 SHALL have parameter ADDR_W, default 18: word-address width, with 2^ADDR_W >= DEPTH.
REQ-004 SHALL have parameter OUTREG, default 0: 0 gives read latency 1, 1 gives read latency 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 enables the post-reset memory clear.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0: word written during the clear.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port clken, input, 1 bit: global clock enable.
REQ-010 SHALL have, for each port p in {s1, s2}, these inputs: p_address (ADDR_W), p_chipselect (1), p_read (1), p_write (1), p_byteenable (DATA_W/8), p_writedata (DATA_W).
REQ-011 SHALL have, for each p, these outputs: p_readdata (DATA_W), p_readdatavalid (1), p_waitrequest (1).
REQ-012 SHALL have port busy, output, 1 bit: high while the clear is in progress.

Function
REQ-013 SHALL accept a transfer on port p in a cycle only when p_chipselect=1, (p_read or p_write)=1 and p_waitrequest=0.
REQ-014 SHALL treat p_read=1 together with p_write=1 as a write only.
REQ-015 SHALL have a control FSM with states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
REQ-016 In CLEAR, the block SHALL write CLEAR_VALUE with all bytes enabled to addresses 0..DEPTH-1, one address per enabled cycle, then enter READY.
REQ-017 The clear SHALL take exactly DEPTH enabled cycles.
REQ-018 In CLEAR, busy=1 and both waitrequests SHALL be 1; in READY, busy=0.
REQ-019 An accepted write SHALL update only the bytes whose byteenable bit is 1.
REQ-020 An accepted read SHALL produce p_readdatavalid=1, with p_readdata valid, exactly 1+OUTREG enabled cycles after acceptance.
REQ-021 Reads SHALL be fully pipelined: one accepted read per cycle per port, with results returned in order.
REQ-022 p_readdatavalid SHALL be 0 in every cycle that does not return a read, and p_readdata is don't-care in those cycles.
REQ-023 An address >= DEPTH: a write SHALL be accepted and discarded; a read SHALL be accepted and return 0 with normal latency.
REQ-024 A read on one port SHALL return the old data when a write to the same address is accepted in the same cycle on either port.
REQ-025 Write collision: if s1 and s2 both request writes to the same address in the same cycle, s1 SHALL be accepted; s2_waitrequest=1 for that cycle, and s2 completes in a following cycle.
REQ-026 Simultaneous requests to different addresses, or any reads, SHALL never stall either port.
REQ-027 clken=0 SHALL freeze all state: FSM, clear address, read pipeline, and the readdatavalid/readdata outputs.
REQ-028 While clken=0, both waitrequests SHALL be 1 and no transfer is accepted.
REQ-029 Storage SHALL be inferred true-dual-port block RAM; memory contents are not altered by reset except via the clear.

Reset
REQ-030 While reset=1 (sampled on the clk edge), the block SHALL hold readdatavalid=0 on both ports and discard any in-flight reads.
REQ-031 While reset=1, busy SHALL be set equal to CLEAR_ON_RESET.
REQ-032 While reset=1, both waitrequests SHALL be 1, and the clear address SHALL be set to 0.
REQ-033 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-034 Reset asserted in READY SHALL rerun the clear when CLEAR_ON_RESET=1.

Verification
REQ-035 Scenario (DEPTH=16, CLEAR_ON_RESET=1): deassert reset -> busy=1 and waitrequests=1 for exactly 16 cycles, then 0; a read of address 5 returns 0x00000000.
REQ-036 Scenario (OUTREG=0): s1 writes 0xDEADBEEF to address 3 with byteenable 4'b1111, then writes 0x000000AA to address 3 with byteenable 4'b0001; s2 reads address 3 -> readdatavalid after 1 cycle with 0xDEADBEAA.
REQ-037 Scenario: s1 and s2 both write address 7 in the same cycle (0x11111111 and 0x22222222) -> s2_waitrequest=1 for one cycle; the final read of address 7 returns 0x22222222.
REQ-038 Scenario (OUTREG=1): back-to-back s1 reads of addresses 0,1,2 holding 10,11,12 -> readdatavalid high for 3 consecutive cycles starting 2 cycles after the first read, with data 10,11,12 in order.
REQ-039 Scenario: reset pulsed when the clear has reached address 8 of 16 -> the clear restarts and busy stays high for 16 further cycles.
REQ-040 Scenario: clken=0 for 3 cycles during a pending read -> readdatavalid is delayed by exactly 3 cycles and the data is unchanged.

Source files
------------

// File: rtl/cpu_onchip_ram_dp_if.sv
// Avalon-MM style slave bus for one port of the dual-port on-chip RAM.
// The master drives the request fields and the slave returns the read data and waitrequest.
interface cpu_onchip_ram_dp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 18
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/cpu_onchip_ram_dp.sv
// True-dual-port on-chip RAM with byte enables, a pipelined read path and a
// post-reset clear sequencer that fills every word with CLEAR_VALUE.
module cpu_onchip_ram_dp #(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       DEPTH          = 153600,
    parameter int unsigned       ADDR_W         = 18,
    parameter int unsigned       OUTREG         = 0,
    parameter int unsigned       CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    cpu_onchip_ram_dp_if.slave   s1,
    cpu_onchip_ram_dp_if.slave   s2,
    output logic                 busy
);
    localparam int unsigned       NB        = DATA_W / 8;
    localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Per-port views of the two buses; index 0 is s1, index 1 is s2.
    logic [ADDR_W-1:0] addr  [2];
    logic [NB-1:0]     be    [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        cs, rd, wr;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read, s1.read};
    assign wr       = {s2.write, s1.write};

    logic             stall, collide, clr_we;
    logic [1:0]       wait_req, in_range, acc, rd_acc, rd_en, wr_en;
    logic [IDX_W-1:0] idx [2];

    always_comb begin
        stall   = reset | ~clken | (state_q == StClear);
        // Same-address write on both ports: s1 wins, s2 retries next cycle.
        collide = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
        wait_req = {stall | collide, stall};
        clr_we   = clken & ~reset & (state_q == StClear);
        for (int p = 0; p < 2; p++) begin
            in_range[p] = ({1'b0, addr[p]} < DEPTH_X);
            idx[p]      = addr[p][IDX_W-1:0];
            acc[p]      = cs[p] & (rd[p] | wr[p]) & ~wait_req[p];
            rd_acc[p]   = acc[p] & ~wr[p];
            rd_en[p]    = rd_acc[p] & in_range[p];
            wr_en[p]    = acc[p] & wr[p] & in_range[p];
        end
    end

    assign s1.waitrequest = wait_req[0];
    assign s2.waitrequest = wait_req[1];
    assign busy           = (state_q == StClear);

    // Storage: read-before-write on each port so a same-cycle write returns old data.
    logic [DATA_W-1:0] mem   [DEPTH];
    logic [DATA_W-1:0] ram_q [2];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q[IDX_W-1:0]] <= CLEAR_VALUE;
        end
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
                ram_q[p] <= mem[idx[p]];
            end
            if (wr_en[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[p][b]) begin
                        mem[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

    logic [1:0]        v1_q, v1_d, inr_q, inr_d, v2_q, v2_d;
    logic [DATA_W-1:0] d2_q [2];
    logic [DATA_W-1:0] d2_d [2];
    logic [DATA_W-1:0] rd1_data [2];

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        v1_d       = v1_q;
        inr_d      = inr_q;
        v2_d       = v2_q;
        d2_d       = d2_q;
        // Out-of-range reads return zero rather than whatever the RAM holds.
        for (int p = 0; p < 2; p++) begin
            rd1_data[p] = inr_q[p] ? ram_q[p] : '0;
        end
        if (reset) begin
            state_d    = (CLEAR_ON_RESET != 0) ? StClear : StReady;
            clr_addr_d = '0;
            v1_d       = '0;
            v2_d       = '0;
        end else if (clken) begin
            case (state_q)
                StClear: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = StReady;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
                default: state_d = StReady;
            endcase
            v1_d  = rd_acc;
            inr_d = in_range;
            v2_d  = v1_q;
            d2_d  = rd1_data;
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        clr_addr_q <= clr_addr_d;
        v1_q       <= v1_d;
        inr_q      <= inr_d;
        v2_q       <= v2_d;
        d2_q       <= d2_d;
    end

    assign s1.readdatavalid = (OUTREG != 0) ? v2_q[0] : v1_q[0];
    assign s2.readdatavalid = (OUTREG != 0) ? v2_q[1] : v1_q[1];
    assign s1.readdata      = (OUTREG != 0) ? d2_q[0] : rd1_data[0];
    assign s2.readdata      = (OUTREG != 0) ? d2_q[1] : rd1_data[1];
endmodule

// File: tb/tb_cpu_onchip_ram_dp.sv
// Bench for cpu_onchip_ram_dp: drives one OUTREG=0 and one OUTREG=1 instance with
// identical directed stimulus and checks both against a cycle-stamped reference model.
module tb_cpu_onchip_ram_dp;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DEP = 16;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic clken  = 1'b1;
    logic busy0, busy1;

    logic [AW-1:0] p_addr [2];
    logic [3:0]    p_be   [2];
    logic [31:0]   p_wd   [2];
    logic [1:0]    p_cs, p_rd, p_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) a1 (), a2 (), b1 (), b2 ();

    assign a1.address = p_addr[0]; assign b1.address = p_addr[0];
    assign a2.address = p_addr[1]; assign b2.address = p_addr[1];
    assign a1.chipselect = p_cs[0]; assign b1.chipselect = p_cs[0];
    assign a2.chipselect = p_cs[1]; assign b2.chipselect = p_cs[1];
    assign a1.read = p_rd[0]; assign b1.read = p_rd[0];
    assign a2.read = p_rd[1]; assign b2.read = p_rd[1];
    assign a1.write = p_wr[0]; assign b1.write = p_wr[0];
    assign a2.write = p_wr[1]; assign b2.write = p_wr[1];
    assign a1.byteenable = p_be[0]; assign b1.byteenable = p_be[0];
    assign a2.byteenable = p_be[1]; assign b2.byteenable = p_be[1];
    assign a1.writedata = p_wd[0]; assign b1.writedata = p_wd[0];
    assign a2.writedata = p_wd[1]; assign b2.writedata = p_wd[1];

    cpu_onchip_ram_dp #(
        .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .OUTREG(0), .CLEAR_ON_RESET(1),
        .CLEAR_VALUE(32'h0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .clken(clken), .s1(a1), .s2(a2), .busy(busy0)
    );

    cpu_onchip_ram_dp #(
        .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .OUTREG(1), .CLEAR_ON_RESET(1),
        .CLEAR_VALUE(32'h0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .clken(clken), .s1(b1), .s2(b2), .busy(busy1)
    );

    // Observed outputs indexed [dut][port].
    logic [1:0]  ov [2];
    logic [1:0]  ow [2];
    logic [31:0] od [2][2];
    logic        ob [2];
    assign ov[0] = {a2.readdatavalid, a1.readdatavalid};
    assign ov[1] = {b2.readdatavalid, b1.readdatavalid};
    assign ow[0] = {a2.waitrequest, a1.waitrequest};
    assign ow[1] = {b2.waitrequest, b1.waitrequest};
    assign od[0][0] = a1.readdata; assign od[0][1] = a2.readdata;
    assign od[1][0] = b1.readdata; assign od[1][1] = b2.readdata;
    assign ob[0] = busy0;
    assign ob[1] = busy1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, remaining clear cycles, and expected returns
    // stamped with the enabled-cycle number in which they must be visible.
    int          clear_left = 0;
    int          ecyc       = 0;
    bit          started    = 0;
    logic [31:0] mmem [DEP];
    bit          ev [2][2][4096];
    logic [31:0] ed [2][2][4096];
    logic        macc [2];
    logic        mw1, mw2;
    logic [31:0] mval;

    function automatic logic coll_now();
        return p_cs[0] & p_wr[0] & p_cs[1] & p_wr[1] & (p_addr[0] == p_addr[1]);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            clear_left = DEP;
            started    = 1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    ev[d][p][ecyc]     = 0;
                    ev[d][p][ecyc + 1] = 0;
                end
            end
        end else if (clken) begin
            mw1 = (clear_left > 0);
            mw2 = mw1 | coll_now();
            macc[0] = p_cs[0] & (p_rd[0] | p_wr[0]) & !mw1;
            macc[1] = p_cs[1] & (p_rd[1] | p_wr[1]) & !mw2;
            ecyc++;
            for (int p = 0; p < 2; p++) begin
                ev[0][p][ecyc]     = 0;
                ev[1][p][ecyc + 1] = 0;
                if (macc[p] && !p_wr[p]) begin
                    mval = (int'(p_addr[p]) < DEP) ? mmem[p_addr[p]] : 32'h0;
                    ev[0][p][ecyc]     = 1;
                    ed[0][p][ecyc]     = mval;
                    ev[1][p][ecyc + 1] = 1;
                    ed[1][p][ecyc + 1] = mval;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (macc[p] && p_wr[p] && int'(p_addr[p]) < DEP) begin
                    for (int b = 0; b < 4; b++) begin
                        if (p_be[p][b]) mmem[p_addr[p]][8*b +: 8] = p_wd[p][8*b +: 8];
                    end
                end
            end
            if (clear_left > 0) begin
                mmem[DEP - clear_left] = 32'h0;
                clear_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            mw1 = reset | !clken | (clear_left > 0);
            mw2 = mw1 | coll_now();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[d%0d]", d), 32'(ob[d]), 32'(clear_left > 0));
                chk($sformatf("s1_waitrequest[d%0d]", d), 32'(ow[d][0]), 32'(mw1));
                chk($sformatf("s2_waitrequest[d%0d]", d), 32'(ow[d][1]), 32'(mw2));
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("readdatavalid[d%0d s%0d]", d, p + 1), 32'(ov[d][p]),
                        32'(ev[d][p][ecyc]));
                    if (ev[d][p][ecyc])
                        chk($sformatf("readdata[d%0d s%0d]", d, p + 1), od[d][p],
                            ed[d][p][ecyc]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input logic c, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        p_cs[p] = c; p_rd[p] = r; p_wr[p] = w;
        p_addr[p] = a; p_be[p] = be; p_wd[p] = d;
    endtask

    task automatic idle();
        setp(0, 0, 0, 0, '0, '0, '0);
        setp(1, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        setp(p, 1, 0, 1, a, be, d);
        tick();
        idle();
    endtask

    // One read; checks latency on both instances and returns their data.
    task automatic rd(input int p, input logic [AW-1:0] a, output logic [31:0] d0,
                      output logic [31:0] d1);
        setp(p, 1, 1, 0, a, '0, '0);
        tick();
        idle();
        @(negedge clk);
        chk("lat1_valid", 32'(ov[0][p]), 32'd1);
        chk("lat2_not_yet", 32'(ov[1][p]), 32'd0);
        d0 = od[0][p];
        @(negedge clk);
        chk("lat2_valid", 32'(ov[1][p]), 32'd1);
        d1 = od[1][p];
        tick();
    endtask

    task automatic count_busy(output int n, output int nw);
        n = 0;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy0 !== 1'b1) break;
            n++;
            if (a1.waitrequest === 1'b1 && a2.waitrequest === 1'b1) nw++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] r0, r1;
    int          n, nw;
    logic [5:0]  exp_v0, exp_v1;
    logic        sv0 [7];
    logic        sv1 [7];
    logic [31:0] sd0 [7];
    logic [31:0] sd1 [7];

    initial begin
        idle();
        reset = 1'b1;
        clken = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Post-reset clear lasts exactly DEPTH cycles, then memory reads zero.
        count_busy(n, nw);
        chk("clear_busy_cycles", n, 16);
        chk("clear_wait_cycles", nw, 16);
        tick();
        rd(0, 5'd5, r0, r1);
        chk("clear_addr5_lat1", r0, 32'h0);
        chk("clear_addr5_lat2", r1, 32'h0);

        // Byte-enable merge on s1, read back through s2, then a partial s2 write.
        wr(0, 5'd3, 4'b1111, 32'hDEADBEEF);
        wr(0, 5'd3, 4'b0001, 32'h000000AA);
        rd(1, 5'd3, r0, r1);
        chk("byteen_s2_lat1", r0, 32'hDEADBEAA);
        chk("byteen_s2_lat2", r1, 32'hDEADBEAA);
        wr(1, 5'd3, 4'b0110, 32'hA5A5A5A5);
        rd(0, 5'd3, r0, r1);
        chk("byteen_mid_lanes", r0, 32'hDEA5A5AA);

        // Same-address write collision: s1 first, s2 stalls one cycle then lands.
        setp(0, 1, 0, 1, 5'd7, 4'hF, 32'h11111111);
        setp(1, 1, 0, 1, 5'd7, 4'hF, 32'h22222222);
        @(negedge clk);
        chk("coll_s1_wait", 32'(a1.waitrequest), 32'd0);
        chk("coll_s2_wait", 32'(a2.waitrequest), 32'd1);
        tick();
        setp(0, 0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("coll_s2_retry_wait", 32'(a2.waitrequest), 32'd0);
        tick();
        idle();
        rd(0, 5'd7, r0, r1);
        chk("coll_final", r0, 32'h22222222);

        // Read on s2 while s1 writes the same address returns the old word.
        wr(0, 5'd9, 4'hF, 32'h12345678);
        setp(0, 1, 0, 1, 5'd9, 4'hF, 32'hCAFEF00D);
        setp(1, 1, 1, 0, 5'd9, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("rdw_old_data", a2.readdata, 32'h12345678);
        tick();
        rd(1, 5'd9, r0, r1);
        chk("rdw_new_data", r0, 32'hCAFEF00D);

        // Out-of-range: write discarded without aliasing, read returns zero.
        setp(0, 1, 0, 1, 5'd20, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        chk("oor_write_accepted", 32'(a1.waitrequest), 32'd0);
        tick();
        idle();
        rd(0, 5'd20, r0, r1);
        chk("oor_read_zero", r0, 32'h0);
        rd(1, 5'd4, r0, r1);
        chk("oor_no_alias", r0, 32'h0);

        // Back-to-back reads on s1 return in order with the configured latency.
        wr(1, 5'd0, 4'hF, 32'd10);
        wr(1, 5'd1, 4'hF, 32'd11);
        wr(1, 5'd2, 4'hF, 32'd12);
        exp_v0 = 6'b001110;
        exp_v1 = 6'b011100;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) setp(0, 1, 1, 0, AW'(c), '0, '0);
            else idle();
            @(negedge clk);
            sv0[c] = ov[0][0]; sv1[c] = ov[1][0];
            sd0[c] = od[0][0]; sd1[c] = od[1][0];
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("pipe_lat1_valid_c%0d", c), 32'(sv0[c]), 32'(exp_v0[c]));
            chk($sformatf("pipe_lat2_valid_c%0d", c), 32'(sv1[c]), 32'(exp_v1[c]));
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("pipe_lat1_data_%0d", c), sd0[c + 1], 32'(10 + c));
            chk($sformatf("pipe_lat2_data_%0d", c), sd1[c + 2], 32'(10 + c));
        end

        // clken low for three cycles while a read is in flight.
        setp(0, 1, 1, 0, 5'd2, '0, '0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            sv0[c] = ov[0][0]; sv1[c] = ov[1][0]; sd1[c] = od[1][0];
            tick();
            if (c == 0) begin
                idle();
                clken = 1'b0;
            end
            if (c == 3) clken = 1'b1;
        end
        chk("freeze_lat2_not_at_2", 32'(sv1[2]), 32'd0);
        chk("freeze_lat2_not_at_4", 32'(sv1[4]), 32'd0);
        chk("freeze_lat2_at_5", 32'(sv1[5]), 32'd1);
        chk("freeze_lat2_data", sd1[5], 32'd12);
        chk("freeze_lat2_drop_6", 32'(sv1[6]), 32'd0);
        chk("freeze_lat1_held_3", 32'(sv0[3]), 32'd1);
        chk("freeze_lat1_drop_5", 32'(sv0[5]), 32'd0);

        // Reset in READY reruns the clear; a second reset mid-clear restarts it.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("midclear_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n, nw);
        chk("restart_busy_cycles", n, 16);
        chk("restart_wait_cycles", nw, 16);
        tick();
        rd(0, 5'd3, r0, r1);
        chk("recleared_addr3", r0, 32'h0);
        rd(1, 5'd9, r0, r1);
        chk("recleared_addr9", r1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
